// File: rtl/pipe_fwd_hazard_unit_pkg.sv
// Shared constants for the forwarding/hazard unit: forwarding codes, stage indices
// and the select-width helper used by the interface, top and per-port matcher.
package pipe_fwd_hazard_unit_pkg;

  localparam int RSIZE_DEF = 4;

  localparam int FWD_RF  = 0;
  localparam int STG_EX  = 1;
  localparam int STG_MEM = 2;
  localparam int STG_WB  = 3;

  function automatic int fsel_width(input int nstage);
    return $clog2(nstage + 1);
  endfunction

endpackage

// File: rtl/pipe_fwd_hazard_unit_if.sv
// Decode-side bus between the decode stage and the hazard unit: source/destination
// tags in, stall and per-port forwarding selects out.
interface pipe_fwd_hazard_unit_if #(
  parameter int RSIZE  = 4,
  parameter int NSTAGE = 3,
  parameter int NRD    = 2,
  parameter int FSEL   = $clog2(NSTAGE + 1)
);

  logic                  id_valid;
  logic [NRD-1:0]        id_ren;
  logic [NRD*RSIZE-1:0]  id_raddr;
  logic                  id_wen;
  logic [RSIZE-1:0]      id_waddr;
  logic                  id_is_load;
  logic                  flush;
  logic                  stall;
  logic [NRD*FSEL-1:0]   fwd_sel;

  modport master (
    output id_valid, id_ren, id_raddr, id_wen, id_waddr, id_is_load, flush,
    input  stall, fwd_sel
  );

  modport slave (
    input  id_valid, id_ren, id_raddr, id_wen, id_waddr, id_is_load, flush,
    output stall, fwd_sel
  );

endinterface

// File: rtl/pipe_fwd_hazard_unit_fwd_port_match.sv
// Per-read-port tag matcher: finds the youngest in-flight producer of one source
// register and reports which stage to forward from, or that the value is not ready.
module pipe_fwd_hazard_unit_fwd_port_match
  import pipe_fwd_hazard_unit_pkg::*;
#(
  parameter int RSIZE      = RSIZE_DEF,
  parameter int NSTAGE     = STG_WB,
  parameter int LOAD_STAGE = STG_MEM,
  parameter int ZERO_REG   = 0,
  parameter int FSEL       = fsel_width(NSTAGE)
) (
  input  logic                    ren,
  input  logic [RSIZE-1:0]        raddr,
  input  logic [NSTAGE-1:0]       wen,
  input  logic [NSTAGE-1:0]       ld,
  input  logic [NSTAGE*RSIZE-1:0] waddr,
  output logic [FSEL-1:0]         fwd_sel,
  output logic                    need_stall
);

  logic            zero_blocked;
  logic [FSEL-1:0] hit_stage;
  logic            unavail;

  assign zero_blocked = (ZERO_REG != 0) && (raddr == '0);

  // Walk oldest to youngest so the youngest matching stage overwrites any older one.
  always_comb begin
    hit_stage = FSEL'(FWD_RF);
    unavail   = 1'b0;
    for (int k = NSTAGE; k >= 1; k--) begin
      if (ren && !zero_blocked && wen[k-1] &&
          (waddr[(k-1)*RSIZE +: RSIZE] == raddr)) begin
        hit_stage = FSEL'(k);
        unavail   = ld[k-1] && (k < LOAD_STAGE);
      end
    end
  end

  assign need_stall = unavail;
  assign fwd_sel    = unavail ? FSEL'(FWD_RF) : hit_stage;

endmodule

// File: rtl/pipe_fwd_hazard_unit.sv
// Forwarding and load-use hazard controller: shifts destination tags of in-flight
// instructions, drives operand forwarding selects, stall, and a stall counter.
module pipe_fwd_hazard_unit
  import pipe_fwd_hazard_unit_pkg::*;
#(
  parameter int RSIZE      = RSIZE_DEF,
  parameter int NSTAGE     = STG_WB,
  parameter int NRD        = 2,
  parameter int LOAD_STAGE = STG_MEM,
  parameter int ZERO_REG   = 0,
  parameter int CNT_W      = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  pipe_fwd_hazard_unit_if.slave   bus,
  output logic [NSTAGE-1:0]       pipe_wen,
  output logic [NSTAGE*RSIZE-1:0] pipe_waddr,
  output logic [CNT_W-1:0]        stall_cnt
);

  localparam int FSEL = fsel_width(NSTAGE);

  logic [NSTAGE-1:0]       wen_q;
  logic [NSTAGE-1:0]       ld_q;
  logic [NSTAGE*RSIZE-1:0] waddr_q;

  logic [NRD-1:0]  port_stall;
  logic [FSEL-1:0] port_sel [NRD];
  logic            stall_int;
  logic            take;
  logic            s1_wen;
  logic            s1_ld;
  logic [RSIZE-1:0] s1_waddr;

  for (genvar p = 0; p < NRD; p++) begin : g_port
    pipe_fwd_hazard_unit_fwd_port_match #(
      .RSIZE      (RSIZE),
      .NSTAGE     (NSTAGE),
      .LOAD_STAGE (LOAD_STAGE),
      .ZERO_REG   (ZERO_REG),
      .FSEL       (FSEL)
    ) u_match (
      .ren        (bus.id_ren[p]),
      .raddr      (bus.id_raddr[p*RSIZE +: RSIZE]),
      .wen        (wen_q),
      .ld         (ld_q),
      .waddr      (waddr_q),
      .fwd_sel    (port_sel[p]),
      .need_stall (port_stall[p])
    );
  end

  // A flushed or invalid decode slot can never stall; otherwise any unready port does.
  always_comb begin
    stall_int   = bus.id_valid && !bus.flush && (|port_stall);
    bus.stall   = stall_int;
    bus.fwd_sel = '0;
    for (int p = 0; p < NRD; p++) begin
      bus.fwd_sel[p*FSEL +: FSEL] = port_sel[p];
    end
  end

  always_comb begin
    take     = bus.id_valid && !bus.flush && !stall_int;
    s1_wen   = take && bus.id_wen;
    s1_ld    = take && bus.id_is_load;
    s1_waddr = take ? bus.id_waddr : '0;
  end

  // The tag pipe never holds: a stalled decode simply injects a bubble into stage 1.
  always_ff @(posedge clk) begin
    if (rst) begin
      wen_q   <= '0;
      ld_q    <= '0;
      waddr_q <= '0;
    end else begin
      wen_q   <= {wen_q[NSTAGE-2:0], s1_wen};
      ld_q    <= {ld_q[NSTAGE-2:0], s1_ld};
      waddr_q <= {waddr_q[(NSTAGE-1)*RSIZE-1:0], s1_waddr};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (stall_int && (stall_cnt != {CNT_W{1'b1}})) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end

  assign pipe_wen   = wen_q;
  assign pipe_waddr = waddr_q;

endmodule

// File: tb/tb_pipe_fwd_hazard_unit.sv
// Directed bench: default-parameter unit for forwarding/stall/flush/reset cases and a
// CNT_W=4, ZERO_REG=1 unit for counter saturation and the hard-wired zero register.
module tb_pipe_fwd_hazard_unit;

  logic        clk;
  logic        rst;
  logic [2:0]  pw1;
  logic [11:0] pwa1;
  logic [15:0] cnt1;
  logic [2:0]  pw2;
  logic [11:0] pwa2;
  logic [3:0]  cnt2;

  int n_checks;
  int n_fails;

  pipe_fwd_hazard_unit_if #(.RSIZE(4), .NSTAGE(3), .NRD(2)) bus1 ();
  pipe_fwd_hazard_unit_if #(.RSIZE(4), .NSTAGE(3), .NRD(2)) bus2 ();

  pipe_fwd_hazard_unit #(
    .RSIZE(4), .NSTAGE(3), .NRD(2), .LOAD_STAGE(2), .ZERO_REG(0), .CNT_W(16)
  ) dut1 (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus1),
    .pipe_wen   (pw1),
    .pipe_waddr (pwa1),
    .stall_cnt  (cnt1)
  );

  pipe_fwd_hazard_unit #(
    .RSIZE(4), .NSTAGE(3), .NRD(2), .LOAD_STAGE(2), .ZERO_REG(1), .CNT_W(4)
  ) dut2 (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus2),
    .pipe_wen   (pw2),
    .pipe_waddr (pwa2),
    .stall_cnt  (cnt2)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // One decode cycle: drive at the falling edge, settle, leave the rising edge to come.
  task automatic applyStimulus(input bit sel2, input bit r, input bit v,
                               input logic [1:0] ren, input logic [3:0] ra0,
                               input logic [3:0] ra1, input bit we,
                               input logic [3:0] wa, input bit ld, input bit fl);
    @(negedge clk);
    rst = r;
    bus1.id_valid = 1'b0; bus1.id_ren = '0; bus1.id_raddr = '0; bus1.id_wen = 1'b0;
    bus1.id_waddr = '0; bus1.id_is_load = 1'b0; bus1.flush = 1'b0;
    bus2.id_valid = 1'b0; bus2.id_ren = '0; bus2.id_raddr = '0; bus2.id_wen = 1'b0;
    bus2.id_waddr = '0; bus2.id_is_load = 1'b0; bus2.flush = 1'b0;
    if (sel2) begin
      bus2.id_valid = v; bus2.id_ren = ren; bus2.id_raddr = {ra1, ra0};
      bus2.id_wen = we; bus2.id_waddr = wa; bus2.id_is_load = ld; bus2.flush = fl;
    end else begin
      bus1.id_valid = v; bus1.id_ren = ren; bus1.id_raddr = {ra1, ra0};
      bus1.id_wen = we; bus1.id_waddr = wa; bus1.id_is_load = ld; bus1.flush = fl;
    end
    #1;
  endtask

  task automatic idleCycles(input bit sel2, input int n);
    for (int i = 0; i < n; i++) applyStimulus(sel2, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs,
                             input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fails  = 0;
    rst = 1'b1;
    bus1.id_valid = 1'b0; bus1.id_ren = '0; bus1.id_raddr = '0; bus1.id_wen = 1'b0;
    bus1.id_waddr = '0; bus1.id_is_load = 1'b0; bus1.flush = 1'b0;
    bus2.id_valid = 1'b0; bus2.id_ren = '0; bus2.id_raddr = '0; bus2.id_wen = 1'b0;
    bus2.id_waddr = '0; bus2.id_is_load = 1'b0; bus2.flush = 1'b0;
    repeat (2) @(posedge clk);

    $display("[TB] reset state");
    applyStimulus(0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0);
    checkOutput("rst_pipe_wen", 32'(pw1), 32'h0);
    checkOutput("rst_stall", 32'(bus1.stall), 32'h0);
    checkOutput("rst_fwd_sel", 32'(bus1.fwd_sel), 32'h0);
    checkOutput("rst_cnt", 32'(cnt1), 32'h0);
    checkOutput("rst_cnt2", 32'(cnt2), 32'h0);

    $display("[TB] ALU to ALU forwarding from EX");
    applyStimulus(0, 0, 1, 2'b00, 0, 0, 1, 1, 0, 0);
    checkOutput("alu_a_stall", 32'(bus1.stall), 32'h0);
    applyStimulus(0, 0, 1, 2'b11, 1, 3, 1, 2, 0, 0);
    checkOutput("alu_b_pipe_wen", 32'(pw1), 32'h1);
    checkOutput("alu_b_waddr1", 32'(pwa1[3:0]), 32'h1);
    checkOutput("alu_b_fwd_sel", 32'(bus1.fwd_sel), 32'h1);
    checkOutput("alu_b_stall", 32'(bus1.stall), 32'h0);
    idleCycles(0, 3);

    $display("[TB] load-use");
    applyStimulus(0, 0, 1, 2'b00, 0, 0, 1, 4, 1, 0);
    checkOutput("lu_lw_stall", 32'(bus1.stall), 32'h0);
    applyStimulus(0, 0, 1, 2'b11, 4, 4, 1, 5, 0, 0);
    checkOutput("lu_stall", 32'(bus1.stall), 32'h1);
    checkOutput("lu_stall_fwd", 32'(bus1.fwd_sel), 32'h0);
    applyStimulus(0, 0, 1, 2'b11, 4, 4, 1, 5, 0, 0);
    checkOutput("lu_held_stall", 32'(bus1.stall), 32'h0);
    checkOutput("lu_held_fwd", 32'(bus1.fwd_sel), 32'hA);
    checkOutput("lu_bubble", 32'(pw1), 32'h2);
    checkOutput("lu_cnt", 32'(cnt1), 32'h1);
    idleCycles(0, 3);

    $display("[TB] youngest producer and WB forwarding");
    applyStimulus(0, 0, 1, 2'b00, 0, 0, 1, 6, 0, 0);
    applyStimulus(0, 0, 1, 2'b00, 0, 0, 1, 6, 0, 0);
    applyStimulus(0, 0, 1, 2'b11, 6, 6, 0, 0, 0, 0);
    checkOutput("young_fwd_ex", 32'(bus1.fwd_sel), 32'h5);
    checkOutput("young_stall", 32'(bus1.stall), 32'h0);
    applyStimulus(0, 0, 1, 2'b11, 6, 6, 0, 0, 0, 0);
    checkOutput("young_fwd_mem", 32'(bus1.fwd_sel), 32'hA);
    applyStimulus(0, 0, 1, 2'b11, 6, 6, 0, 0, 0, 0);
    checkOutput("young_fwd_wb", 32'(bus1.fwd_sel), 32'hF);
    applyStimulus(0, 0, 1, 2'b11, 6, 6, 0, 0, 0, 0);
    checkOutput("retired_fwd_rf", 32'(bus1.fwd_sel), 32'h0);

    $display("[TB] youngest producer is an unready load");
    applyStimulus(0, 0, 1, 2'b00, 0, 0, 1, 9, 0, 0);
    applyStimulus(0, 0, 1, 2'b00, 0, 0, 1, 9, 1, 0);
    applyStimulus(0, 0, 1, 2'b01, 9, 0, 0, 0, 0, 0);
    checkOutput("yl_stall", 32'(bus1.stall), 32'h1);
    checkOutput("yl_fwd", 32'(bus1.fwd_sel), 32'h0);
    applyStimulus(0, 0, 1, 2'b01, 9, 0, 0, 0, 0, 0);
    checkOutput("yl_held_stall", 32'(bus1.stall), 32'h0);
    checkOutput("yl_held_fwd", 32'(bus1.fwd_sel), 32'h2);
    checkOutput("yl_cnt", 32'(cnt1), 32'h2);
    idleCycles(0, 3);

    $display("[TB] flush over load-use");
    applyStimulus(0, 0, 1, 2'b00, 0, 0, 1, 7, 1, 0);
    applyStimulus(0, 0, 1, 2'b11, 7, 7, 1, 8, 0, 1);
    checkOutput("fl_stall", 32'(bus1.stall), 32'h0);
    applyStimulus(0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0);
    checkOutput("fl_bubble", 32'(pw1), 32'h2);
    checkOutput("fl_cnt", 32'(cnt1), 32'h2);
    idleCycles(0, 3);

    $display("[TB] reset during stall");
    applyStimulus(0, 0, 1, 2'b00, 0, 0, 1, 10, 0, 0);
    applyStimulus(0, 0, 1, 2'b00, 0, 0, 1, 11, 0, 0);
    applyStimulus(0, 0, 1, 2'b00, 0, 0, 1, 12, 1, 0);
    applyStimulus(0, 1, 1, 2'b01, 12, 0, 1, 13, 0, 0);
    checkOutput("rs_pre_stall", 32'(bus1.stall), 32'h1);
    checkOutput("rs_pre_full", 32'(pw1), 32'h7);
    applyStimulus(0, 0, 1, 2'b01, 12, 0, 1, 13, 0, 0);
    checkOutput("rs_pipe_wen", 32'(pw1), 32'h0);
    checkOutput("rs_stall", 32'(bus1.stall), 32'h0);
    checkOutput("rs_fwd", 32'(bus1.fwd_sel), 32'h0);
    checkOutput("rs_cnt", 32'(cnt1), 32'h0);
    idleCycles(0, 3);

    $display("[TB] stall counter saturation");
    for (int i = 0; i < 20; i++) begin
      applyStimulus(1, 0, 1, 2'b00, 0, 0, 1, 1, 1, 0);
      applyStimulus(1, 0, 1, 2'b01, 1, 0, 1, 2, 0, 0);
      if (i == 19) checkOutput("sat_last_stall", 32'(bus2.stall), 32'h1);
      applyStimulus(1, 0, 1, 2'b01, 1, 0, 1, 2, 0, 0);
      if (i == 13) checkOutput("sat_cnt14", 32'(cnt2), 32'hE);
    end
    checkOutput("sat_cnt15", 32'(cnt2), 32'hF);
    idleCycles(1, 3);

    $display("[TB] hard-wired zero register");
    applyStimulus(1, 0, 1, 2'b00, 0, 0, 1, 0, 1, 0);
    applyStimulus(1, 0, 1, 2'b11, 0, 0, 1, 5, 0, 0);
    checkOutput("zr_stall", 32'(bus2.stall), 32'h0);
    checkOutput("zr_fwd", 32'(bus2.fwd_sel), 32'h0);
    applyStimulus(1, 0, 1, 2'b00, 0, 0, 1, 3, 1, 0);
    applyStimulus(1, 0, 1, 2'b01, 3, 0, 0, 0, 0, 0);
    checkOutput("zr_r3_waddr", 32'(pwa2[3:0]), 32'h3);
    checkOutput("zr_r3_stall", 32'(bus2.stall), 32'h1);
    checkOutput("zr_cnt_held", 32'(cnt2), 32'hF);
    idleCycles(1, 2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
